bist_fail_logger: RTL and testbench

- Downstream consumer of the March-C BIST top level.
- Samples the per-cycle `fail` strobe with the registered `fail_addr` and the SRAM `data_out` word.
- Logs failing address/data pairs into a small first-word-fall-through FIFO and keeps a saturating fail count and the first-fail address.
- Reports end-of-test pass/fail status to the host, which drains the log through a valid/read-enable handshake.

---
 rtl/bist_fail_logger_if.sv | 39 +++
 rtl/bist_fail_logger.sv | 154 +++++++++++++++
 tb/tb_bist_fail_logger.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bist_fail_logger_if.sv
`default_nettype none
// ============================================================================
// Module      : bist_fail_logger_if
// Description : BIST fail strobe inputs and host log-drain handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface bist_fail_logger_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int CNT_W  = 10
);
    logic              start;
    logic              bist_done;
    logic              fail;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_data;
    logic              rd_en;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  fail_count;
    logic [ADDR_W-1:0] first_fail_addr;
    logic              overflow;
    logic              done;
    logic              pass;

    modport slave (
        input  start, bist_done, fail, fail_addr, fail_data, rd_en,
        output rd_valid, rd_addr, rd_data, fail_count, first_fail_addr,
               overflow, done, pass
    );

    modport master (
        output start, bist_done, fail, fail_addr, fail_data, rd_en,
        input  rd_valid, rd_addr, rd_data, fail_count, first_fail_addr,
               overflow, done, pass
    );
endinterface
`default_nettype wire

// File: rtl/bist_fail_logger.sv
`default_nettype none
// ============================================================================
// Module      : bist_fail_logger
// Description : Logs March-C BIST fails into a FWFT FIFO, counts fails and
//               reports pass/fail. Optional macro FAIL_LOG_DEDUP_EN suppresses
//               pushes that repeat the most recently pushed address.
// Revision    : 1.0 - initial release
// ============================================================================
module bist_fail_logger #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 10
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bist_fail_logger_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [PTR_W:0]   c_depth   = (PTR_W+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOG  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_done;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_occ;
    logic [CNT_W-1:0]  r_fail_count;
    logic [ADDR_W-1:0] r_first_fail_addr;
    logic              r_overflow;

    logic              w_log;
    logic              w_dup;
    logic              w_pop;
    logic              w_full;
    logic              w_push;
    logic              w_drop;

    // start always wins over a fail in the same cycle
    assign w_log  = (r_state == S_LOG) && bus.fail && !bus.start;
    assign w_pop  = bus.rd_en && (r_occ != '0);
    assign w_full = (r_occ == c_depth);
    assign w_push = w_log && !w_dup && (!w_full || w_pop);
    assign w_drop = w_log && !w_dup && w_full && !w_pop;

`ifdef FAIL_LOG_DEDUP_EN
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_last_vld;

    assign w_dup = r_last_vld && (bus.fail_addr == r_last_addr);

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_push) begin
            r_last_addr <= bus.fail_addr;
            r_last_vld  <= 1'b1;
        end
    end
`else
    assign w_dup = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = S_LOG;
        end else if ((r_state == S_LOG) && bus.bist_done) begin
            w_state_nxt = S_DONE;
        end
    end

    // FSM: outputs
    always_comb begin
        w_done = (r_state == S_DONE);
    end

    // Storage has no reset; only occupancy decides what is visible
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= bus.fail_addr;
            r_mem_data[r_wr_ptr] <= bus.fail_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
                2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            r_fail_count      <= '0;
            r_first_fail_addr <= '0;
            r_overflow        <= 1'b0;
        end else begin
            if (w_log) begin
                if (r_fail_count != c_cnt_max) begin
                    r_fail_count <= r_fail_count + CNT_W'(1);
                end
                if (r_fail_count == '0) begin
                    r_first_fail_addr <= bus.fail_addr;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.rd_valid        = (r_occ != '0);
    assign bus.rd_addr         = r_mem_addr[r_rd_ptr];
    assign bus.rd_data         = r_mem_data[r_rd_ptr];
    assign bus.fail_count      = r_fail_count;
    assign bus.first_fail_addr = r_first_fail_addr;
    assign bus.overflow        = r_overflow;
    assign bus.done            = w_done;
    assign bus.pass            = w_done && (r_fail_count == '0);
endmodule
`default_nettype wire

// File: tb/tb_bist_fail_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_bist_fail_logger
// Description : Directed self-checking bench with a scoreboard of logged fails.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bist_fail_logger;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bist_fail_logger_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    bist_fail_logger #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    ent_t              sb[$];
    int                m_cnt;
    logic [ADDR_W-1:0] m_first;
    bit                m_ovf;
    bit                m_done;
    bit                m_logging;
    logic [ADDR_W-1:0] m_last;
    bit                m_last_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt    = 0;
        m_first  = '0;
        m_ovf    = 1'b0;
        m_done   = 1'b0;
        m_last_v = 1'b0;
        m_last   = '0;
    endtask

    task automatic check_status(input string tag);
        check({tag, ".fail_count"}, 32'(bus.fail_count), 32'(m_cnt));
        check({tag, ".first_fail_addr"}, 32'(bus.first_fail_addr), 32'(m_first));
        check({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
        check({tag, ".done"}, 32'(bus.done), 32'(m_done));
        check({tag, ".pass"}, 32'(bus.pass), 32'(m_done && (m_cnt == 0)));
        check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'(sb.size() != 0));
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        model_clear();
        m_logging = 1'b1;
    endtask

    task automatic do_bist_done();
        bus.bist_done = 1'b1;
        cyc();
        bus.bist_done = 1'b0;
        if (m_logging) begin
            m_logging = 1'b0;
            m_done    = 1'b1;
        end
    endtask

    // One fail strobe, optionally with a concurrent pop; model follows the DUT rules
    task automatic do_fail(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input bit rd, input string tag);
        ent_t e;
        bit   dup;
        bus.fail      = 1'b1;
        bus.fail_addr = a;
        bus.fail_data = d;
        bus.rd_en     = rd;
        if (rd && sb.size() != 0) begin
            check({tag, ".pop_addr"}, 32'(bus.rd_addr), 32'(sb[0].a));
            check({tag, ".pop_data"}, 32'(bus.rd_data), 32'(sb[0].d));
            void'(sb.pop_front());
        end
        if (m_logging) begin
            if (m_cnt == 0) m_first = a;
            if (m_cnt != CNT_MAX) m_cnt++;
`ifdef FAIL_LOG_DEDUP_EN
            dup = m_last_v && (m_last == a);
`else
            dup = 1'b0;
`endif
            if (!dup) begin
                if (sb.size() < DEPTH) begin
                    e.a = a;
                    e.d = d;
                    sb.push_back(e);
                    m_last   = a;
                    m_last_v = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        cyc();
        bus.fail  = 1'b0;
        bus.rd_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 2 * DEPTH) begin
            check({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd1);
            check({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(sb[0].a));
            check({tag, ".rd_data"}, 32'(bus.rd_data), 32'(sb[0].d));
            bus.rd_en = 1'b1;
            cyc();
            bus.rd_en = 1'b0;
            void'(sb.pop_front());
            guard++;
        end
        check({tag, ".empty"}, 32'(bus.rd_valid), 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.bist_done = 1'b0;
        bus.fail      = 1'b0;
        bus.fail_addr = '0;
        bus.fail_data = '0;
        bus.rd_en     = 1'b0;
        model_clear();
        m_logging = 1'b0;

        // Reset then idle
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        repeat (10) cyc();
        check_status("reset");
        check("reset.rd_addr_hidden_valid", 32'(bus.rd_valid), 32'd0);
        do_fail(8'h12, 4'h1, 1'b0, "idle_fail");
        cyc();
        check_status("idle_fail");

        // Clean run
        do_start();
        repeat (50) cyc();
        check_status("clean_log");
        do_bist_done();
        check_status("clean_done");

        // Fail in DONE is ignored
        do_fail(8'h22, 4'h2, 1'b0, "done_fail");
        check_status("done_fail");

        // Three fails
        do_start();
        do_fail(8'h05, 4'hA, 1'b0, "three");
        do_fail(8'h80, 4'h3, 1'b0, "three");
        do_fail(8'hFF, 4'h0, 1'b0, "three");
        do_bist_done();
        check_status("three_done");
        drain("three_drain");

        // Overflow
        do_start();
        for (int i = 0; i < 10; i++) begin
            do_fail(8'(i), 4'(i + 3), 1'b0, "ovf_fill");
        end
        check_status("ovf_full");
        do_fail(8'd10, 4'hC, 1'b1, "ovf_rdwr");
        check_status("ovf_rdwr");
        drain("ovf_drain");
        check_status("ovf_after");

        // Fail plus bist_done in the same cycle is still logged
        do_start();
        bus.bist_done = 1'b1;
        do_fail(8'h7E, 4'h9, 1'b0, "fail_done");
        bus.bist_done = 1'b0;
        m_logging = 1'b0;
        m_done    = 1'b1;
        check_status("fail_done");
        drain("fail_done_drain");

        // Restart mid-run with a concurrent fail
        do_start();
        for (int i = 0; i < 4; i++) begin
            do_fail(8'(8'h20 + i), 4'(i), 1'b0, "restart_pre");
        end
        check_status("restart_pre");
        bus.start     = 1'b1;
        bus.fail      = 1'b1;
        bus.fail_addr = 8'h33;
        bus.fail_data = 4'h3;
        cyc();
        bus.start = 1'b0;
        bus.fail  = 1'b0;
        model_clear();
        m_logging = 1'b1;
        check_status("restart");
        do_fail(8'h44, 4'h4, 1'b0, "restart_post");
        check_status("restart_post");
        drain("restart_drain");

        // Dedup pattern
        do_start();
        do_fail(8'h40, 4'h1, 1'b0, "dedup");
        do_fail(8'h40, 4'h2, 1'b0, "dedup");
        do_fail(8'h41, 4'h3, 1'b0, "dedup");
        do_fail(8'h40, 4'h4, 1'b0, "dedup");
        check_status("dedup");
        drain("dedup_drain");

        // Counter saturation while draining every cycle
        do_start();
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            do_fail(8'(i), 4'(i), 1'b1, "sat");
        end
        check_status("sat");
        drain("sat_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
